div_result_bcd: RTL and testbench
=================================

# div_result_bcd

Sequential binary-to-BCD converter that sits directly downstream of the `Divisor` stage. It captures one `quotient`/`remainder` pair through a valid/ready handshake. It then converts both operands to packed BCD in parallel using an iterative shift-add-3 (double-dabble) engine, one bit per clock. The result is presented to the display/driver stage with its own valid/ready handshake.

## Interface
- `Nbits`, 4, width of `quotient`, `remainder`, `divisor`; matches the `Divisor` instance.
- `DIGITS`, 2, BCD digits per operand; must satisfy 10^DIGITS > 2^Nbits − 1.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `quotient`  in  Nbits  quotient from `Divisor`.
- `remainder`  in  Nbits  remainder from `Divisor`.
- `divisor`  in  Nbits  divisor that produced this result; used only for the zero check.
- `in_valid`  in  1  input pair is valid.
- `in_ready`  out  1  block can accept a pair.
- `q_bcd`  out  4*DIGITS  packed BCD of the quotient; digit 0 is in bits [3:0].
- `r_bcd`  out  4*DIGITS  packed BCD of the remainder.
- `err`  out  1  divide-by-zero flag (see Configuration).
- `out_valid`  out  1  `q_bcd`, `r_bcd` and `err` hold a valid result.
- `out_ready`  in  1  downstream consumes the result.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On an edge with `in_valid`=1:
    - latch `quotient`, `remainder` (and `divisor`) into working registers;
    - clear both BCD accumulators;
    - set the bit counter to Nbits;
    - go to SHIFT.
- **SHIFT**
  - On each edge, for both operands in parallel:
    - add 3 to every accumulator digit ≥ 5;
    - shift {accumulator, binary} left by 1;
    - decrement the counter.
  - When the counter reaches 0, on that edge:
    - copy the accumulators into the `q_bcd`/`r_bcd` output registers;
    - go to DONE.
- **DONE**
  - `out_valid`=1.
  - On an edge with `out_ready`=1, go to IDLE.
- Output registers change only on entry to DONE. They hold their value through IDLE until the next result.
- Handshake signals that are not acted on are ignored:
  - `in_valid` outside IDLE (`in_ready`=0);
  - `out_ready` outside DONE.
- Arithmetic is unsigned. Digit add-3 is 4-bit and never overflows, because the digit is ≤ 9 before correction.
- Reset values (async, on `reset_n`=0):
  - state IDLE, `in_ready`=1, `out_valid`=0;
  - `q_bcd`=0, `r_bcd`=0, `err`=0;
  - all working registers 0.
- Reset mid-SHIFT or mid-DONE returns immediately to IDLE. The pending result is discarded and `out_valid` never asserts for it.

## Timing
- Acceptance: the edge where IDLE and `in_valid`=1.
- `out_valid` rises Nbits edges after the acceptance edge (4 for defaults).
- Minimum initiation interval is Nbits+2 cycles: accept edge, Nbits shift edges, and one DONE edge with `out_ready`=1.
- `in_ready` rises on the same edge that leaves DONE. It is a registered decode of state, with no combinational path from `out_ready`.
- All outputs are registered and remain stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- Macro: `DIV_ZERO_CHECK_EN`.
- **Defined**
  - A pair accepted with `divisor`=0 skips SHIFT: the next edge enters DONE.
  - In that case `err`=1 and `q_bcd`/`r_bcd` are all 4'hF nibbles (blank code).
  - `err` is cleared on the next acceptance with a non-zero divisor.
- **Undefined**
  - `divisor` is ignored and `err` is constant 0.
  - All pairs are converted normally.

## Test plan
- Reset: assert `reset_n`=0 with random inputs → `in_ready`=1, `out_valid`=0, `q_bcd`=8'h00, `r_bcd`=8'h00, `err`=0.
- Basic conversion: quotient=6, remainder=0 (12/2), `in_valid` pulse → `out_valid` exactly 4 edges later, `q_bcd`=8'h06, `r_bcd`=8'h00.
- Full-scale conversion with backpressure: quotient=15, remainder=13 → `q_bcd`=8'h15, `r_bcd`=8'h13. Then hold `out_ready`=0 for 5 cycles while pulsing `in_valid` → outputs stable, no new acceptance.
- Back-to-back stream: `in_valid` and `out_ready` held high, pairs (9,1), (7,3), (10,5) → accepts every 6 cycles; results 8'h09/8'h01, 8'h07/8'h03, 8'h10/8'h05 in order.
- Reset mid-operation: assert `reset_n` low 2 edges into SHIFT → immediate IDLE, no `out_valid` for that pair, next pair converts correctly.
- Divide-by-zero, `DIV_ZERO_CHECK_EN` defined: divisor=0 → `out_valid` 1 edge after acceptance, `err`=1, `q_bcd`=`r_bcd`=8'hFF. Undefined build: same stimulus → normal conversion with `err`=0.

Source files
------------

// File: rtl/div_result_bcd.sv
// div_result_bcd: captures one quotient/remainder pair from the Divisor stage and converts both
// operands to packed BCD with a one-bit-per-clock shift-add-3 (double-dabble) engine.
// Optional feature macro: DIV_ZERO_CHECK_EN (divide-by-zero flag with blank-code outputs).
module div_result_bcd #(
  parameter int unsigned Nbits  = 4,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [Nbits-1:0]      quotient,
  input  logic [Nbits-1:0]      remainder,
  input  logic [Nbits-1:0]      divisor,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic [4*DIGITS-1:0]   r_bcd,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CatW = BcdW + Nbits;
  localparam int unsigned CntW = $clog2(Nbits + 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [Nbits-1:0]    q_bin_q;
  logic [Nbits-1:0]    r_bin_q;
  logic [BcdW-1:0]     q_acc_q;
  logic [BcdW-1:0]     r_acc_q;

  logic [CatW-1:0]     q_cat;
  logic [CatW-1:0]     r_cat;

  // Add 3 to every digit >= 5 so the following left shift carries correctly into the next digit.
  function automatic logic [BcdW-1:0] dabble_fix(input logic [BcdW-1:0] acc);
    logic [BcdW-1:0] res;
    res = acc;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // One double-dabble step for both operands: correct digits, then shift {acc, bin} left by one.
  always_comb begin
    q_cat = {dabble_fix(q_acc_q), q_bin_q} << 1;
    r_cat = {dabble_fix(r_acc_q), r_bin_q} << 1;
  end

`ifdef DIV_ZERO_CHECK_EN
  logic div_zero_q;
  logic err_q;

  assign err = err_q;
`else
  // Divisor only matters for the zero check, which is not built here.
  logic unused_divisor;

  assign unused_divisor = ^divisor;
  assign err            = 1'b0;
`endif

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      q_bin_q    <= '0;
      r_bin_q    <= '0;
      q_acc_q    <= '0;
      r_acc_q    <= '0;
      q_bcd      <= '0;
      r_bcd      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      div_zero_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            q_bin_q  <= quotient;
            r_bin_q  <= remainder;
            q_acc_q  <= '0;
            r_acc_q  <= '0;
            cnt_q    <= CntW'(Nbits);
            in_ready <= 1'b0;
            state_q  <= StShift;
`ifdef DIV_ZERO_CHECK_EN
            div_zero_q <= (divisor == '0);
            // A good divisor clears a stale error flag as soon as it is accepted.
            if (divisor != '0) begin
              err_q <= 1'b0;
            end
`endif
          end
        end

        StShift: begin
`ifdef DIV_ZERO_CHECK_EN
          if (div_zero_q) begin
            // Blank code on every nibble; conversion is skipped entirely.
            q_bcd     <= '1;
            r_bcd     <= '1;
            err_q     <= 1'b1;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else
`endif
          begin
            q_acc_q <= q_cat[CatW-1 -: BcdW];
            q_bin_q <= q_cat[Nbits-1:0];
            r_acc_q <= r_cat[CatW-1 -: BcdW];
            r_bin_q <= r_cat[Nbits-1:0];
            cnt_q   <= cnt_q - 1'b1;
            // Last step: publish the freshly shifted accumulators directly.
            if (cnt_q == CntW'(1)) begin
              q_bcd     <= q_cat[CatW-1 -: BcdW];
              r_bcd     <= r_cat[CatW-1 -: BcdW];
              out_valid <= 1'b1;
              state_q   <= StDone;
            end
          end
        end

        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end

        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed testbench for div_result_bcd; honours DIV_ZERO_CHECK_EN for the divide-by-zero case.
module tb_div_result_bcd;

  logic       clock;
  logic       reset_n;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic [3:0] divisor;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] q_bcd;
  logic [7:0] r_bcd;
  logic       err;
  logic       out_valid;
  logic       out_ready;

  int n_vec;
  int n_err;

  div_result_bcd #(
    .Nbits  (4),
    .DIGITS (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .quotient  (quotient),
    .remainder (remainder),
    .divisor   (divisor),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one pair (caller guarantees in_ready) and count edges until out_valid rises.
  task automatic xfer(input logic [3:0] q, input logic [3:0] r, input logic [3:0] d,
                      output int edges);
    quotient  = q;
    remainder = r;
    divisor   = d;
    in_valid  = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    edges    = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        edges = k;
        break;
      end
    end
  endtask

  // Consume the current result with a single out_ready pulse.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  int         edges;
  int         acc_cyc[3];
  logic [7:0] exp_q[3];
  logic [7:0] exp_r[3];
  logic [3:0] pq[3];
  logic [3:0] pr[3];

  initial begin
    n_vec     = 0;
    n_err     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset with arbitrary inputs present.
    quotient  = 4'($urandom);
    remainder = 4'($urandom);
    divisor   = 4'($urandom);
    in_valid  = 1'($urandom);
    out_ready = 1'($urandom);
    reset_n   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q_bcd", 32'(q_bcd), 32'h00);
    check("rst_r_bcd", 32'(r_bcd), 32'h00);
    check("rst_err", 32'(err), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b1;
    @(posedge clock);
    #1;

    // Basic conversion 12/2.
    xfer(4'd6, 4'd0, 4'd2, edges);
    check("basic_latency", 32'(edges), 32'd4);
    check("basic_q", 32'(q_bcd), 32'h06);
    check("basic_r", 32'(r_bcd), 32'h00);
    check("basic_err", 32'(err), 32'd0);
    drain();
    check("basic_drain_valid", 32'(out_valid), 32'd0);
    check("basic_drain_ready", 32'(in_ready), 32'd1);

    // Full scale, then backpressure with in_valid pulsing.
    xfer(4'd15, 4'd13, 4'd1, edges);
    check("full_latency", 32'(edges), 32'd4);
    check("full_q", 32'(q_bcd), 32'h15);
    check("full_r", 32'(r_bcd), 32'h13);
    quotient  = 4'd3;
    remainder = 4'd2;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      @(posedge clock);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_q", 32'(q_bcd), 32'h15);
      check("bp_r", 32'(r_bcd), 32'h13);
    end
    in_valid = 1'b0;
    drain();
    // Nothing was accepted during backpressure, so the block stays idle.
    repeat (6) @(posedge clock);
    #1;
    check("bp_no_accept_valid", 32'(out_valid), 32'd0);
    check("bp_no_accept_q", 32'(q_bcd), 32'h15);

    // Back-to-back stream with in_valid and out_ready held high.
    pq[0] = 4'd9;  pr[0] = 4'd1;  exp_q[0] = 8'h09; exp_r[0] = 8'h01;
    pq[1] = 4'd7;  pr[1] = 4'd3;  exp_q[1] = 8'h07; exp_r[1] = 8'h03;
    pq[2] = 4'd10; pr[2] = 4'd5;  exp_q[2] = 8'h10; exp_r[2] = 8'h05;
    begin
      int idx;
      int res;
      idx       = 0;
      res       = 0;
      divisor   = 4'd1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && res < 3; cyc++) begin
        if (out_valid) begin
          check("b2b_q", 32'(q_bcd), 32'(exp_q[res]));
          check("b2b_r", 32'(r_bcd), 32'(exp_r[res]));
          res++;
        end
        if (in_ready) begin
          if (idx < 3) begin
            quotient     = pq[idx];
            remainder    = pr[idx];
            in_valid     = 1'b1;
            acc_cyc[idx] = cyc;
            idx++;
          end else begin
            in_valid = 1'b0;
          end
        end
        @(posedge clock);
        #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_results", 32'(res), 32'd3);
      check("b2b_ii_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      check("b2b_ii_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
    end
    @(posedge clock);
    #1;

    // Reset two edges into SHIFT.
    quotient  = 4'd12;
    remainder = 4'd3;
    divisor   = 4'd4;
    in_valid  = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clock);
        #1;
        if (out_valid) seen++;
      end
      check("midrst_no_valid", 32'(seen), 32'd0);
    end
    check("midrst_q_cleared", 32'(q_bcd), 32'h00);
    xfer(4'd11, 4'd2, 4'd3, edges);
    check("post_rst_latency", 32'(edges), 32'd4);
    check("post_rst_q", 32'(q_bcd), 32'h11);
    check("post_rst_r", 32'(r_bcd), 32'h02);
    drain();

    // Divide by zero.
    xfer(4'd5, 4'd0, 4'd0, edges);
`ifdef DIV_ZERO_CHECK_EN
    check("dz_latency", 32'(edges), 32'd1);
    check("dz_err", 32'(err), 32'd1);
    check("dz_q", 32'(q_bcd), 32'hFF);
    check("dz_r", 32'(r_bcd), 32'hFF);
    drain();
    xfer(4'd8, 4'd1, 4'd2, edges);
    check("dz_clear_err", 32'(err), 32'd0);
    check("dz_clear_q", 32'(q_bcd), 32'h08);
`else
    check("dz_latency", 32'(edges), 32'd4);
    check("dz_err", 32'(err), 32'd0);
    check("dz_q", 32'(q_bcd), 32'h05);
    check("dz_r", 32'(r_bcd), 32'h00);
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
